fft_frame_loader: RTL and testbench



---
 rtl/fft_pkg.sv | 13 +
 rtl/fft_frame_loader_if.sv | 26 ++
 rtl/fft_frame_loader.sv | 140 ++++++++++++++
 tb/tb_fft_frame_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath and its frame loader.
package fft_pkg;
    localparam int FFT_N  = 16;
    localparam int FFT_DW = 16;
    localparam int FFT_Q  = 15;

    typedef logic signed [FFT_DW-1:0] sample_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream in, whole frame out: the two handshakes around the frame loader.
interface fft_frame_loader_if #(
    parameter int N          = fft_pkg::FFT_N,
    parameter int DATA_WIDTH = fft_pkg::FFT_DW
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_real;
    logic signed [DATA_WIDTH-1:0] in_imag;
    logic                         in_last;
    logic signed [DATA_WIDTH-1:0] frame_real [0:N-1];
    logic signed [DATA_WIDTH-1:0] frame_imag [0:N-1];
    logic                         frame_valid;
    logic                         frame_ready;
    logic                         frame_err;

    modport slave (
        input  in_valid, in_real, in_imag, in_last, frame_ready,
        output in_ready, frame_real, frame_imag, frame_valid, frame_err
    );

    modport master (
        output in_valid, in_real, in_imag, in_last, frame_ready,
        input  in_ready, frame_real, frame_imag, frame_valid, frame_err
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Double-buffered stream-to-frame loader feeding the combinational 16-point FFT.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N          = FFT_N,
    parameter int DATA_WIDTH = FFT_DW
) (
    input logic              clk,
    input logic              rst_n,
    fft_frame_loader_if.slave bus
);
    localparam int              IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t                       state_r;
    state_t                       state_s;
    logic [IDX_W-1:0]             wr_idx_r;
    logic signed [DATA_WIDTH-1:0] fill_real_r [0:N-1];
    logic signed [DATA_WIDTH-1:0] fill_imag_r [0:N-1];
    logic signed [DATA_WIDTH-1:0] out_real_r  [0:N-1];
    logic signed [DATA_WIDTH-1:0] out_imag_r  [0:N-1];
    logic                         frame_valid_r;
    logic                         frame_err_r;

    logic sample_acc_s;
    logic frame_acc_s;
    logic complete_s;
    logic short_s;
    logic copy_s;
    logic copy_in_s;
    logic frame_valid_s;

    // Next-state and copy decisions; in_ready is a pure decode of state_r.
    always_comb begin
        state_s       = state_r;
        copy_s        = 1'b0;
        copy_in_s     = 1'b0;
        frame_valid_s = frame_valid_r;
        sample_acc_s  = bus.in_valid && (state_r == FILL);
        frame_acc_s   = frame_valid_r && bus.frame_ready;
        complete_s    = sample_acc_s && (wr_idx_r == LAST_IDX);
        short_s       = sample_acc_s && bus.in_last && (wr_idx_r != LAST_IDX);
        case (state_r)
            FILL: begin
                if (complete_s) begin
                    if (!frame_valid_r || frame_acc_s) begin
                        copy_s    = 1'b1;
                        copy_in_s = 1'b1;
                    end else begin
                        state_s = HOLD;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            HOLD: begin
                if (frame_acc_s) begin
                    copy_s  = 1'b1;
                    state_s = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
        if (copy_s) begin
            frame_valid_s = 1'b1;
        end else if (frame_acc_s) begin
            frame_valid_s = 1'b0;
        end else begin
            frame_valid_s = frame_valid_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Write pointer and handshake flags; a short frame just rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_r      <= '0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            frame_valid_r <= frame_valid_s;
            frame_err_r   <= short_s;
            if (sample_acc_s) begin
                wr_idx_r <= (complete_s || short_s) ? '0 : wr_idx_r + IDX_W'(1);
            end
        end
    end

    // Fill bank: every accepted sample lands at wr_idx, including the last one,
    // so a frame parked in HOLD is complete in this bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                fill_real_r[i] <= '0;
                fill_imag_r[i] <= '0;
            end
        end else if (sample_acc_s) begin
            fill_real_r[wr_idx_r] <= bus.in_real;
            fill_imag_r[wr_idx_r] <= bus.in_imag;
        end
    end

    // Output bank: the completing sample bypasses the fill bank on a direct copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                out_real_r[i] <= '0;
                out_imag_r[i] <= '0;
            end
        end else if (copy_s) begin
            for (int i = 0; i < N; i++) begin
                if (copy_in_s && (i == N - 1)) begin
                    out_real_r[i] <= bus.in_real;
                    out_imag_r[i] <= bus.in_imag;
                end else begin
                    out_real_r[i] <= fill_real_r[i];
                    out_imag_r[i] <= fill_imag_r[i];
                end
            end
        end
    end

    assign bus.in_ready    = (state_r == FILL);
    assign bus.frame_valid = frame_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.frame_real  = out_real_r;
    assign bus.frame_imag  = out_imag_r;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: directed frames, stalls, short frames, reset.
module tb_fft_frame_loader;
    localparam int N  = 16;
    localparam int DW = 16;
    localparam int PW = N * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fft_frame_loader_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    fft_frame_loader #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp     = 0;
    int n_err     = 0;
    int stall_cnt = 0;
    logic [PW-1:0] exp_real_q [$];
    logic [PW-1:0] exp_imag_q [$];

    function automatic logic [PW-1:0] pack_real();
        logic [PW-1:0] p;
        for (int k = 0; k < N; k++) p[k*DW +: DW] = bus.frame_real[k];
        return p;
    endfunction

    function automatic logic [PW-1:0] pack_imag();
        logic [PW-1:0] p;
        for (int k = 0; k < N; k++) p[k*DW +: DW] = bus.frame_imag[k];
        return p;
    endfunction

    function automatic logic [PW-1:0] gen(input int base, input int step);
        logic [PW-1:0] p;
        int v;
        for (int k = 0; k < N; k++) begin
            v = base + k * step;
            p[k*DW +: DW] = v[DW-1:0];
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [PW-1:0] fr, input logic [PW-1:0] fi);
        exp_real_q.push_back(fr);
        exp_imag_q.push_back(fi);
    endtask

    // Scoreboard monitor: compares the output bank whenever a frame is accepted.
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid && bus.frame_ready) begin
            if (exp_real_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: got %0h expected none", pack_real());
            end else begin
                chk("frame_real", pack_real(), exp_real_q.pop_front());
                chk("frame_imag", pack_imag(), exp_imag_q.pop_front());
            end
        end
    end

    task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] im, input logic last);
        int   waits;
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_real  = r;
        bus.in_imag  = im;
        bus.in_last  = last;
        waits = 0;
        ok    = 1'b0;
        while (!ok && waits < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected 1", waits);
        end else if (waits > 1) begin
            stall_cnt++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_range(input logic [PW-1:0] fr, input logic [PW-1:0] fi,
                              input int lo, input int hi, input int last_at, input int gap_pct);
        for (int k = lo; k <= hi; k++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            send(fr[k*DW +: DW], fi[k*DW +: DW], (k == N - 1) || (k == last_at));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1_vals [N] = '{0, 12679, 8673, 0, 992, 3547, 0, -1451,
                            1451, 0, -3547, -992, 0, -8673, -12679, 0};
        logic [PW-1:0] t1r, zero, fa_r, fa_i, fb_r, fb_i, fc_r, fc_i, fs_r, fh_r, fh_i, fj_r, fj_i;
        logic [PW-1:0] fr [3];
        logic [PW-1:0] fi [3];
        for (int k = 0; k < N; k++) t1r[k*DW +: DW] = t1_vals[k][DW-1:0];
        zero = '0;
        bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0;
        bus.in_last = 1'b0; bus.frame_ready = 1'b0;

        // Reset values
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_frame_valid", bus.frame_valid, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        chk("rst_frame_real", pack_real(), zero);
        chk("rst_frame_imag", pack_imag(), zero);
        @(posedge clk); #1;

        // Single frame, no stalls
        send_range(t1r, zero, 0, 14, -1, 0);
        chk("t1_valid_before_last", bus.frame_valid, 1'b0);
        send_range(t1r, zero, 15, 15, -1, 0);
        chk("t1_valid_after_last", bus.frame_valid, 1'b1);
        chk("t1_direct_real", pack_real(), t1r);
        push(t1r, zero);
        bus.frame_ready = 1'b1;
        idle(1);
        bus.frame_ready = 1'b0;
        chk("t1_valid_dropped", bus.frame_valid, 1'b0);

        // Two frames with no consumer: second one parks in HOLD
        fa_r = gen(100, 7);   fa_i = gen(0, -5);
        fb_r = gen(-300, 11); fb_i = gen(40, 3);
        fc_r = gen(5000, -13); fc_i = gen(-7, 2);
        send_range(fa_r, fa_i, 0, 15, -1, 0);
        send_range(fb_r, fb_i, 0, 15, -1, 0);
        chk("hold_in_ready", bus.in_ready, 1'b0);
        chk("hold_frame_valid", bus.frame_valid, 1'b1);
        idle(3);
        chk("hold_in_ready_later", bus.in_ready, 1'b0);
        chk("hold_output_frame1", pack_real(), fa_r);
        push(fa_r, fa_i);
        push(fb_r, fb_i);
        bus.frame_ready = 1'b1;
        idle(1);
        bus.frame_ready = 1'b0;
        chk("release_in_ready", bus.in_ready, 1'b1);
        chk("release_valid", bus.frame_valid, 1'b1);
        chk("release_output_frame2", pack_real(), fb_r);

        // Frame accept coinciding with frame completion
        send_range(fc_r, fc_i, 0, 14, -1, 0);
        push(fc_r, fc_i);
        bus.frame_ready = 1'b1;
        send_range(fc_r, fc_i, 15, 15, -1, 0);
        chk("simul_valid", bus.frame_valid, 1'b1);
        chk("simul_output", pack_real(), fc_r);
        chk("simul_in_ready", bus.in_ready, 1'b1);
        idle(1);
        chk("simul_drained", bus.frame_valid, 1'b0);

        // Back-to-back frames with frame_ready tied high
        stall_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            fr[f] = gen(1000 * (f + 1), f + 1);
            fi[f] = gen(-50 * f, -(f + 2));
            push(fr[f], fi[f]);
        end
        for (int f = 0; f < 3; f++) begin
            send_range(fr[f], fi[f], 0, 15, -1, 0);
            chk("stream_valid_after_frame", bus.frame_valid, 1'b1);
        end
        chk("stream_no_stall", stall_cnt, 0);

        // Short frame: in_last at index 5
        fs_r = gen(-20000, 9);
        send_range(fs_r, fs_r, 0, 5, 5, 0);
        chk("short_err_pulse", bus.frame_err, 1'b1);
        chk("short_no_frame", bus.frame_valid, 1'b0);
        idle(1);
        chk("short_err_clear", bus.frame_err, 1'b0);
        fc_r = gen(321, 17); fc_i = gen(-321, 19);
        push(fc_r, fc_i);
        send_range(fc_r, fc_i, 0, 15, -1, 0);
        idle(2);

        // Random input gaps, values 1..16
        fh_r = gen(1, 1); fh_i = gen(-1, -1);
        push(fh_r, fh_i);
        send_range(fh_r, fh_i, 0, 15, -1, 30);
        idle(2);

        // Asynchronous reset in the middle of a frame
        bus.frame_ready = 1'b0;
        fj_r = gen(777, -3); fj_i = gen(12, 12);
        send_range(gen(9999, 1), gen(8888, 1), 0, 8, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_frame_valid", bus.frame_valid, 1'b0);
        chk("midrst_frame_real", pack_real(), zero);
        chk("midrst_frame_err", bus.frame_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.frame_ready = 1'b1;
        push(fj_r, fj_i);
        send_range(fj_r, fj_i, 0, 15, -1, 0);
        idle(3);

        chk("scoreboard_drained", exp_real_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
